// File: rtl/loader_pkg.sv
// Purpose: shared constants and FSM state encoding for the instruction-memory program loader.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
//
// Contents:
//   ADDR_W_DEF / INSTR_W_DEF / BYTE_W_DEF : default widths (address matches PC width)
//   state_e                               : loader FSM states
package loader_pkg;

  localparam int ADDR_W_DEF  = 8;
  localparam int INSTR_W_DEF = 16;
  localparam int BYTE_W_DEF  = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_HI   = 3'd2,
    ST_LO   = 3'd3,
    ST_WR   = 3'd4,
    ST_CHK  = 3'd5,
    ST_FIN  = 3'd6
  } state_e;

endpackage

// File: rtl/im_word_packer.sv
// Purpose: latches the hi/lo bytes of one instruction word; with LOADER_CHECKSUM_EN it
//          also keeps a running XOR over every byte it is told to accumulate.
// Latency: 1 cycle from a byte strobe to the updated wdata / xor_acc.
// Backpressure: none; the strobes are already qualified transfers from the loader FSM.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clr        : clears the XOR accumulator at the start of a load
//   hi_we      : latch byte_data into wdata[2*BYTE_W-1:BYTE_W]
//   lo_we      : latch byte_data into wdata[BYTE_W-1:0]
//   acc_we     : (LOADER_CHECKSUM_EN only) XOR byte_data into the accumulator
//   byte_data  : stream byte
//   wdata      : packed word {hi, lo}
//   xor_acc    : (LOADER_CHECKSUM_EN only) running XOR
module im_word_packer
  import loader_pkg::*;
#(
  parameter int BYTE_W = BYTE_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                hi_we,
  input  logic                lo_we,
`ifdef LOADER_CHECKSUM_EN
  input  logic                acc_we,
  output logic [BYTE_W-1:0]   xor_acc,
`endif
  input  logic [BYTE_W-1:0]   byte_data,
  output logic [2*BYTE_W-1:0] wdata
);

  logic [BYTE_W-1:0] hi_q, hi_d;
  logic [BYTE_W-1:0] lo_q, lo_d;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (hi_we) hi_d = byte_data;
    if (lo_we) lo_d = byte_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign wdata = {hi_q, lo_q};

`ifdef LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] acc_q, acc_d;

  // clr wins so the header byte accumulates into a fresh value on a new load
  always_comb begin
    acc_d = acc_q;
    if (clr)         acc_d = '0;
    else if (acc_we) acc_d = acc_q ^ byte_data;
  end

  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign xor_acc = acc_q;
`endif

endmodule

// File: rtl/im_program_loader.sv
// Purpose: writes a byte stream into instruction RAM as 16-bit words while holding the CPU.
// Latency: lo byte accepted at t -> im_we at t+1; done/cpu_hold release at t+2 (checksum
//          build: at t+1 after the checksum byte).
// Backpressure: byte_ready depends on state only; low in IDLE/WR/FIN, byte_valid=0 just waits.
//
// Optional feature macro: LOADER_CHECKSUM_EN (adds CHK state and XOR check; else error=0).
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   start                  : one-cycle pulse, begins a load when idle
//   byte_valid/byte_data   : input byte stream
//   byte_ready             : loader accepts a byte this cycle
//   im_we/im_waddr/im_wdata: instruction RAM write port
//   cpu_hold               : stalls PC/IR during a load
//   done, error            : load outcome levels
module im_program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int BYTE_W  = BYTE_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               byte_valid,
  input  logic [BYTE_W-1:0]  byte_data,
  output logic               byte_ready,
  output logic               im_we,
  output logic [ADDR_W-1:0]  im_waddr,
  output logic [INSTR_W-1:0] im_wdata,
  output logic               cpu_hold,
  output logic               done,
  output logic               error
);

  // one extra bit so a header of all-ones (256 words) is representable
  localparam int CNT_W = ADDR_W + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic              we_q, we_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              xfer;

  assign byte_ready = (state_q == ST_HDR) || (state_q == ST_HI) ||
                      (state_q == ST_LO)  || (state_q == ST_CHK);
  assign xfer       = byte_valid && byte_ready;

`ifdef LOADER_CHECKSUM_EN
  logic              err_q, err_d;
  logic [BYTE_W-1:0] xor_acc;
`endif

  im_word_packer #(
    .BYTE_W   (BYTE_W)
  ) u_packer (
    .clk      (clk),
    .rst      (rst),
    .clr      ((state_q == ST_IDLE) && start),
    .hi_we    ((state_q == ST_HI) && xfer),
    .lo_we    ((state_q == ST_LO) && xfer),
`ifdef LOADER_CHECKSUM_EN
    .acc_we   (xfer && (state_q != ST_CHK)),
    .xor_acc  (xor_acc),
`endif
    .byte_data(byte_data),
    .wdata    (im_wdata)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    we_d    = 1'b0;
    hold_d  = hold_q;
    done_d  = done_q;
`ifdef LOADER_CHECKSUM_EN
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          hold_d  = 1'b1;
          done_d  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
          err_d   = 1'b0;
`endif
          addr_d  = '0;
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        if (xfer) begin
          rem_d   = CNT_W'(byte_data) + CNT_W'(1);
          state_d = ST_HI;
        end
      end
      ST_HI: begin
        if (xfer) state_d = ST_LO;
      end
      ST_LO: begin
        // write strobe is registered so it lines up with the WR state
        if (xfer) begin
          we_d    = 1'b1;
          state_d = ST_WR;
        end
      end
      ST_WR: begin
        addr_d = addr_q + 1'b1;
        rem_d  = rem_q - 1'b1;
        if (rem_d != '0) begin
          state_d = ST_HI;
        end else begin
`ifdef LOADER_CHECKSUM_EN
          state_d = ST_CHK;
`else
          // outcome is set on entry to FIN so it is visible during the FIN cycle
          done_d  = 1'b1;
          hold_d  = 1'b0;
          state_d = ST_FIN;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (xfer) begin
          hold_d  = 1'b0;
          state_d = ST_IDLE;
          if (byte_data == xor_acc) begin
            done_d = 1'b1;
            err_d  = 1'b0;
          end else begin
            done_d = 1'b0;
            err_d  = 1'b1;
          end
        end
      end
`endif
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      we_q    <= 1'b0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      we_q    <= we_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
`ifdef LOADER_CHECKSUM_EN
      err_q   <= err_d;
`endif
    end
  end

  assign im_we    = we_q;
  assign im_waddr = addr_q;
  assign cpu_hold = hold_q;
  assign done     = done_q;
`ifdef LOADER_CHECKSUM_EN
  assign error    = err_q;
`else
  assign error    = 1'b0;
`endif

endmodule

// File: tb/tb_im_program_loader.sv
module tb_im_program_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        im_we;
  logic [7:0]  im_waddr;
  logic [15:0] im_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int n_checks = 0;
  int n_errors = 0;
  int wr_count = 0;

  logic [23:0] sb[$];        // expected writes {addr, data}
  logic [7:0]  payload[$];   // bytes of the next load, hi/lo pairs
  logic [7:0]  exp_addr;
  logic [7:0]  bench_xor;

  im_program_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .im_we     (im_we),
    .im_waddr  (im_waddr),
    .im_wdata  (im_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every im_we must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && im_we === 1'b1) begin
      wr_count++;
      if (sb.size() == 0) begin
        check("unexpected_we", {24'd0, im_waddr}, 32'hFFFF_FFFF);
      end else begin
        logic [23:0] e;
        e = sb.pop_front();
        check("we_addr", {24'd0, im_waddr}, {24'd0, e[23:16]});
        check("we_data", {16'd0, im_wdata}, {16'd0, e[15:0]});
      end
    end
  end

  // Caller is 1 time unit after a rising edge; returns 1 time unit after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int  n;
    bit  took;
    n = 0;
    took = 1'b0;
    byte_valid = 1'b0;
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
    byte_data  = b;
    byte_valid = 1'b1;
    while (!took && n < 100) begin
      @(negedge clk);
      took = byte_ready;
      @(posedge clk);
      #1;
      n++;
    end
    byte_valid = 1'b0;
    if (!took) check("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Streams header + payload (+ checksum byte in the checksum build) and fills the scoreboard.
  task automatic run_load(input int gap, input bit corrupt);
    int          words;
    logic [7:0]  hdr;
    words = payload.size() / 2;
    hdr = 8'(words - 1);
    pulse_start();
    exp_addr  = 8'd0;
    bench_xor = hdr;
    send_byte(hdr, gap);
    for (int i = 0; i < words; i++) begin
      send_byte(payload[2*i], gap);
      sb.push_back({exp_addr, payload[2*i], payload[2*i+1]});
      exp_addr++;
      bench_xor = bench_xor ^ payload[2*i] ^ payload[2*i+1];
      send_byte(payload[2*i+1], gap);
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(corrupt ? (bench_xor ^ 8'h01) : bench_xor, gap);
`else
    if (corrupt) check("corrupt_unsupported", 32'd0, 32'd1);
`endif
  endtask

  task automatic wait_outcome(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!(done === 1'b1 || error === 1'b1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check(tag, 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_we",    {31'd0, im_we},      32'd0);
    check("rst_hold",  {31'd0, cpu_hold},   32'd0);
    check("rst_done",  {31'd0, done},       32'd0);
    check("rst_error", {31'd0, error},      32'd0);
    check("rst_ready", {31'd0, byte_ready}, 32'd0);
    check("rst_addr",  {24'd0, im_waddr},   32'd0);
    check("rst_wdata", {16'd0, im_wdata},   32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // T1: single word, exact completion latency
    pulse_start();
    @(negedge clk);
    check("t1_hold_after_start", {31'd0, cpu_hold},   32'd1);
    check("t1_ready_hdr",        {31'd0, byte_ready}, 32'd1);
    @(posedge clk);
    #1;
    wr_count = 0;
    exp_addr = 8'd0;
    send_byte(8'h00, 0);
    send_byte(8'h12, 0);
    sb.push_back({8'h00, 16'h1234});
    send_byte(8'h34, 0);
    @(negedge clk);
    check("t1_we_t1",     {31'd0, im_we},      32'd1);
    check("t1_ready_wr",  {31'd0, byte_ready}, 32'd0);
    check("t1_done_t1",   {31'd0, done},       32'd0);
`ifndef LOADER_CHECKSUM_EN
    @(negedge clk);
    check("t1_done_t2",   {31'd0, done},       32'd1);
    check("t1_hold_t2",   {31'd0, cpu_hold},   32'd0);
    check("t1_we_t2",     {31'd0, im_we},      32'd0);
    repeat (3) @(negedge clk);
    check("t1_done_level", {31'd0, done},      32'd1);
    check("t1_error",      {31'd0, error},     32'd0);
`endif
    @(posedge clk);
    #1;
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h26, 0);
    @(negedge clk);
    check("t1_chk_done", {31'd0, done},  32'd1);
    @(posedge clk);
    #1;
`endif
    check("t1_sb_empty", sb.size(), 32'd0);
    check("t1_wr_count", wr_count,  32'd1);

    // T2: three words with 3-cycle valid gaps
    wr_count = 0;
    payload = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
    run_load(3, 1'b0);
    wait_outcome("t2_outcome_timeout");
    repeat (4) @(posedge clk);
    #1;
    check("t2_done",     {31'd0, done},     32'd1);
    check("t2_hold",     {31'd0, cpu_hold}, 32'd0);
    check("t2_sb_empty", sb.size(),         32'd0);
    check("t2_wr_count", wr_count,          32'd3);

    // T3: 256 words, address wraps
    wr_count = 0;
    payload.delete();
    for (int i = 0; i < 512; i++) payload.push_back(8'($urandom_range(0, 255)));
    run_load(0, 1'b0);
    wait_outcome("t3_outcome_timeout");
    @(negedge clk);
    check("t3_done",      {31'd0, done},   32'd1);
    check("t3_addr_wrap", {24'd0, im_waddr}, 32'd0);
    check("t3_sb_empty",  sb.size(),       32'd0);
    check("t3_wr_count",  wr_count,        32'd256);
    @(posedge clk);
    #1;

    // T4: reset after the second word's hi byte, then reload
    wr_count = 0;
    pulse_start();
    exp_addr = 8'd0;
    send_byte(8'h03, 0);
    send_byte(8'h11, 0);
    sb.push_back({8'h00, 16'h1122});
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("t4_hold",  {31'd0, cpu_hold},   32'd0);
    check("t4_done",  {31'd0, done},       32'd0);
    check("t4_we",    {31'd0, im_we},      32'd0);
    check("t4_ready", {31'd0, byte_ready}, 32'd0);
    check("t4_sb_empty_before_reload", sb.size(), 32'd0);
    check("t4_wr_count_before_reload", wr_count,  32'd1);
    @(posedge clk);
    #1;
    wr_count = 0;
    payload = '{8'h55, 8'h66};
    run_load(1, 1'b0);
    wait_outcome("t4_outcome_timeout");
    check("t4_reload_sb_empty", sb.size(), 32'd0);
    check("t4_reload_wr_count", wr_count,  32'd1);

    // T5: start pulsed while waiting for a hi byte is ignored
    wr_count = 0;
    pulse_start();
    exp_addr = 8'd0;
    send_byte(8'h01, 0);
    pulse_start();
    @(negedge clk);
    check("t5_hold_after_stray_start", {31'd0, cpu_hold}, 32'd1);
    @(posedge clk);
    #1;
    send_byte(8'h9A, 0);
    sb.push_back({8'h00, 16'h9ABC});
    send_byte(8'hBC, 0);
    send_byte(8'hDE, 2);
    pulse_start();
    sb.push_back({8'h01, 16'hDEF0});
    send_byte(8'hF0, 0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h01 ^ 8'h9A ^ 8'hBC ^ 8'hDE ^ 8'hF0, 0);
`endif
    wait_outcome("t5_outcome_timeout");
    check("t5_done",     {31'd0, done}, 32'd1);
    check("t5_sb_empty", sb.size(),     32'd0);
    check("t5_wr_count", wr_count,      32'd2);

`ifdef LOADER_CHECKSUM_EN
    // T6: checksum match and mismatch
    payload = '{8'h12, 8'h34};
    run_load(0, 1'b0);
    @(negedge clk);
    check("t6_ok_done",  {31'd0, done},     32'd1);
    check("t6_ok_error", {31'd0, error},    32'd0);
    check("t6_ok_hold",  {31'd0, cpu_hold}, 32'd0);
    @(posedge clk);
    #1;
    run_load(0, 1'b1);
    @(negedge clk);
    check("t6_bad_done",  {31'd0, done},     32'd0);
    check("t6_bad_error", {31'd0, error},    32'd1);
    check("t6_bad_hold",  {31'd0, cpu_hold}, 32'd0);
    check("t6_sb_empty",  sb.size(),         32'd0);
    @(posedge clk);
    #1;
`endif

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
